demux: RTL and testbench
========================

Name: demux

Overview:
- Registered 1-to-2 parallel data demultiplexer with valid/ready handshaking; the inverse of the datapath 2:1 mux.
- Steers each accepted input word to output channel 1 or channel 2, selected by a steering bit sampled with the word.
- Each channel has a 2-entry buffer, so a stalled channel does not block traffic steered to the other channel.
- Used between the core and peripheral sinks, e.g. routing encoder output words to a bitstream writer or a debug port.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_WIDTH, 16, width of the per-channel transfer counters.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- datai  input  WIDTH  input data word.
- sel  input  1  steering bit: 0 routes to channel 1, 1 routes to channel 2.
- validi  input  1  input word and sel are valid.
- readyi  output  1  block can accept the word on datai/sel this cycle.
- data1  output  WIDTH  channel 1 head-of-buffer word.
- valid1  output  1  channel 1 buffer non-empty.
- ready1  input  1  channel 1 sink accepts data1.
- data2  output  WIDTH  channel 2 head-of-buffer word.
- valid2  output  1  channel 2 buffer non-empty.
- ready2  input  1  channel 2 sink accepts data2.
- count1  output  CNT_WIDTH  number of words delivered on channel 1, wrapping.
- count2  output  CNT_WIDTH  number of words delivered on channel 2, wrapping.

Behaviour:
- Reset (nreset low, asynchronous):
  - Both buffers are emptied; read pointer, write pointer and occupancy are all 0.
  - valid1 = valid2 = 0; data1 = data2 = 0; count1 = count2 = 0.
  - readyi = 1 once reset is released.
  - Reset asserted mid-transfer discards all buffered words; no partial output follows reset release.
- Input handshake:
  - A word transfers when validi && readyi at a rising edge.
  - readyi = (sel ? occ2 : occ1) != 2. It depends only on sel and registered occupancy, never on ready1 or ready2, so there is no combinational ready path.
  - A transferred word is written into the buffer of the selected channel only; the other channel is unchanged.
  - validi low means no write, regardless of sel.
- Output handshake (per channel n):
  - A word transfers when validn && readyn at a rising edge.
  - validn = (occn != 0).
  - datan is the oldest word in the buffer (FIFO order) and is stable while validn && !readyn.
  - Each output transfer increments countn by 1, wrapping from 2^CNT_WIDTH-1 to 0.
- Latency: a word accepted at edge k is visible on datan/validn after edge k (1 cycle), provided the buffer was empty.
- Throughput: 1 word/cycle sustained per channel when readyn is held high. Simultaneous push and pop on one channel leaves occupancy unchanged.
- Occupancy update per channel: occ_next = occ + push - pop. Push is only possible when occ < 2; pop is only possible when occ > 0.
- Boundary conditions:
  - Full channel (occ = 2): readyi drops only while sel points at that channel. Words for the other channel continue to flow.
  - Pointer wrap: 1-bit read and write pointers toggle per pop/push; occupancy is tracked with 2 bits.
  - Values of sel or datai while validi is low are ignored.
  - readyn asserted while validn is low has no effect; the count does not change.
- No internal state machine beyond the per-channel buffer control; all outputs except readyi are driven from registers.

Test Plan:
- Reset and idle: hold nreset low for 2 cycles, then release -> valid1 = valid2 = 0, count1 = count2 = 0, readyi = 1. Assert nreset while occ1 = 2 -> valid1 falls immediately (asynchronous) and count1 holds 0.
- Basic steering: send 0x11111111 with sel = 0, then 0x22222222 with sel = 1, both readies high -> data1 = 0x11111111 one cycle after its accept and data2 = 0x22222222 one cycle after its accept; count1 = count2 = 1.
- Backpressure and fill: ready1 = 0; send 0xA0, 0xA1, 0xA2 with sel = 0 -> first two accepted, readyi = 0 on the third. Raise ready1 -> outputs 0xA0, 0xA1, 0xA2 in order, count1 = 3.
- Channel independence: channel 1 full with ready1 = 0; send 0xB0 with sel = 1 and ready2 = 1 -> readyi = 1, 0xB0 appears on data2, and channel 1 contents are unchanged.
- Sustained throughput: 100 back-to-back words, alternating sel, all readies high -> readyi never drops, count1 = count2 = 50, order is preserved per channel.
- Counter wrap: with CNT_WIDTH = 4, deliver 17 words on channel 2 -> count2 = 1.

Source files
------------

// File: rtl/demux.sv
// demux: registered 1-to-2 demultiplexer with a 2-entry FIFO per output channel
// Ports: clock/nreset (async active-low); datai/sel/validi/readyi input handshake;
// data1/valid1/ready1 and data2/valid2/ready2 per-channel output handshakes;
// count1/count2 wrapping counts of words delivered on each channel.
module demux #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [WIDTH-1:0]     datai,
  input  logic                 sel,
  input  logic                 validi,
  output logic                 readyi,
  output logic [WIDTH-1:0]     data1,
  output logic                 valid1,
  input  logic                 ready1,
  output logic [WIDTH-1:0]     data2,
  output logic                 valid2,
  input  logic                 ready2,
  output logic [CNT_WIDTH-1:0] count1,
  output logic [CNT_WIDTH-1:0] count2
);
  logic [WIDTH-1:0]     mem_q [2][2];
  logic [WIDTH-1:0]     mem_d [2][2];
  logic [1:0]           occ_q [2];
  logic [1:0]           occ_d [2];
  logic [CNT_WIDTH-1:0] cnt_q [2];
  logic [CNT_WIDTH-1:0] cnt_d [2];
  logic [1:0]           rp_q, rp_d, wp_q, wp_d;
  logic [1:0]           push, pop, rdy;
  assign rdy    = {ready2, ready1};
  // Only sel and registered occupancy: no combinational path from ready1/ready2.
  assign readyi = (sel ? occ_q[1] : occ_q[0]) != 2'd2;
  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    rp_d  = rp_q;
    wp_d  = wp_q;
    push  = '0;
    pop   = '0;
    for (int c = 0; c < 2; c++) begin
      push[c] = validi && readyi && (c == 0 ? !sel : sel);
      pop[c]  = (occ_q[c] != 2'd0) && rdy[c];
      if (push[c]) mem_d[c][wp_q[c]] = datai;
      wp_d[c]  = wp_q[c] ^ push[c];
      rp_d[c]  = rp_q[c] ^ pop[c];
      occ_d[c] = occ_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      cnt_d[c] = cnt_q[c] + {{(CNT_WIDTH-1){1'b0}}, pop[c]};
    end
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mem_q <= '{default: '0};
      occ_q <= '{default: '0};
      cnt_q <= '{default: '0};
      rp_q  <= '0;
      wp_q  <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      rp_q  <= rp_d;
      wp_q  <= wp_d;
    end
  end
  assign data1  = mem_q[0][rp_q[0]];
  assign data2  = mem_q[1][rp_q[1]];
  assign valid1 = occ_q[0] != 2'd0;
  assign valid2 = occ_q[1] != 2'd0;
  assign count1 = cnt_q[0];
  assign count2 = cnt_q[1];
endmodule

// File: tb/tb_demux.sv
// tb_demux: directed table-driven bench for demux, plus a 4-bit-counter instance for wrap
module tb_demux;
  logic        clock = 0, nreset = 0, sel = 0, validi = 0, ready1 = 0, ready2 = 0;
  logic [31:0] datai = 0;
  logic        readyi, valid1, valid2, readyi_w, valid1_w, valid2_w;
  logic [31:0] data1, data2, data1_w, data2_w;
  logic [15:0] count1, count2;
  logic [3:0]  count1_w, count2_w;
  int total = 0, passed = 0;

  demux dut (.clock(clock), .nreset(nreset), .datai(datai), .sel(sel), .validi(validi),
    .readyi(readyi), .data1(data1), .valid1(valid1), .ready1(ready1), .data2(data2),
    .valid2(valid2), .ready2(ready2), .count1(count1), .count2(count2));

  demux #(.WIDTH(32), .CNT_WIDTH(4)) dut_w (.clock(clock), .nreset(nreset), .datai(datai),
    .sel(sel), .validi(validi), .readyi(readyi_w), .data1(data1_w), .valid1(valid1_w),
    .ready1(ready1), .data2(data2_w), .valid2(valid2_w), .ready2(ready2),
    .count1(count1_w), .count2(count2_w));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        v, s;
    logic [31:0] d;
    logic        r1, r2, rdy, v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
    logic [15:0] c1, c2;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] q1[$], q2[$];
  int drops;

  initial begin
    // v  s  d             r1 r2 rdy v1 d1            v2 d2            c1 c2
    tbl[0]  = '{1, 0, 32'h11111111, 1, 1, 1, 1, 32'h11111111, 0, 0,            0, 0};
    tbl[1]  = '{1, 1, 32'h22222222, 1, 1, 1, 0, 0,            1, 32'h22222222, 1, 0};
    tbl[2]  = '{0, 0, 32'hDEADBEEF, 1, 1, 1, 0, 0,            0, 0,            1, 1};
    tbl[3]  = '{1, 0, 32'hA0,       0, 1, 1, 1, 32'hA0,       0, 0,            1, 1};
    tbl[4]  = '{1, 0, 32'hA1,       0, 1, 1, 1, 32'hA0,       0, 0,            1, 1};
    tbl[5]  = '{1, 0, 32'hA2,       0, 1, 0, 1, 32'hA0,       0, 0,            1, 1};
    tbl[6]  = '{1, 1, 32'hB0,       0, 1, 1, 1, 32'hA0,       1, 32'hB0,       1, 1};
    tbl[7]  = '{1, 0, 32'hA2,       1, 1, 0, 1, 32'hA1,       0, 0,            2, 2};
    tbl[8]  = '{1, 0, 32'hA2,       1, 1, 1, 1, 32'hA2,       0, 0,            3, 2};
    tbl[9]  = '{0, 1, 32'h0,        1, 1, 1, 0, 0,            0, 0,            4, 2};
    tbl[10] = '{0, 0, 32'h5,        1, 1, 1, 0, 0,            0, 0,            4, 2};

    tick;
    tick;
    nreset = 1;
    #1;
    chk("rst_valid1", valid1, 0);
    chk("rst_valid2", valid2, 0);
    chk("rst_data1", data1, 0);
    chk("rst_data2", data2, 0);
    chk("rst_count1", count1, 0);
    chk("rst_count2", count2, 0);
    chk("rst_readyi", readyi, 1);

    for (int i = 0; i < 11; i++) begin
      validi = tbl[i].v; sel = tbl[i].s; datai = tbl[i].d;
      ready1 = tbl[i].r1; ready2 = tbl[i].r2;
      #1;
      chk($sformatf("vec%0d_readyi", i), readyi, tbl[i].rdy);
      tick;
      chk($sformatf("vec%0d_valid1", i), valid1, tbl[i].v1);
      if (tbl[i].v1) chk($sformatf("vec%0d_data1", i), data1, tbl[i].d1);
      chk($sformatf("vec%0d_valid2", i), valid2, tbl[i].v2);
      if (tbl[i].v2) chk($sformatf("vec%0d_data2", i), data2, tbl[i].d2);
      chk($sformatf("vec%0d_count1", i), count1, tbl[i].c1);
      chk($sformatf("vec%0d_count2", i), count2, tbl[i].c2);
      chk($sformatf("vec%0d_count2_w", i), count2_w, tbl[i].c2[3:0]);
    end

    drops = 0;
    for (int i = 0; i < 100; i++) begin
      validi = 1; sel = 1'(i % 2); datai = 32'hC0000000 + i; ready1 = 1; ready2 = 1;
      #1;
      if (!readyi) drops++;
      tick;
      if (readyi || 1) begin
        if (sel) q2.push_back(datai); else q1.push_back(datai);
      end
      chk("sus_valid1", valid1, q1.size() != 0);
      if (q1.size() != 0) chk("sus_data1", data1, q1.pop_front());
      chk("sus_valid2", valid2, q2.size() != 0);
      if (q2.size() != 0) chk("sus_data2", data2, q2.pop_front());
    end
    validi = 0;
    tick;
    chk("sus_drops", drops, 0);
    chk("sus_valid1_end", valid1, 0);
    chk("sus_valid2_end", valid2, 0);
    chk("sus_count1", count1, 54);
    chk("sus_count2", count2, 52);
    chk("sus_count2_w", count2_w, 4);

    nreset = 0;
    tick;
    tick;
    nreset = 1;
    for (int i = 0; i < 17; i++) begin
      validi = 1; sel = 1; datai = 32'hE0 + i; ready2 = 1;
      tick;
    end
    validi = 0;
    tick;
    chk("wrap_count2", count2, 17);
    chk("wrap_count2_w", count2_w, 1);
    chk("wrap_count1", count1, 0);

    ready1 = 0; validi = 1; sel = 0; datai = 32'hF0;
    tick;
    datai = 32'hF1;
    tick;
    validi = 0;
    #1;
    chk("full_valid1", valid1, 1);
    chk("full_data1", data1, 32'hF0);
    chk("full_readyi", readyi, 0);
    #2;
    nreset = 0;
    #1;
    chk("arst_valid1", valid1, 0);
    chk("arst_count1", count1, 0);
    chk("arst_readyi", readyi, 1);
    tick;
    nreset = 1;
    ready1 = 1;
    tick;
    tick;
    chk("post_rst_valid1", valid1, 0);
    chk("post_rst_count1", count1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
